// File: rtl/blt_feed_pkg.sv
// Shared definitions for the blocky DSP feeder: register map,
// sequencer states, status bit layout and the default silence word.
package blt_feed_pkg;

    localparam logic [5:0] REG_W0   = 6'd0;
    localparam logic [5:0] REG_W1   = 6'd1;
    localparam logic [5:0] REG_W2   = 6'd2;
    localparam logic [5:0] REG_W3   = 6'd3;
    localparam logic [5:0] REG_STAT = 6'd4;

    localparam int ST_CNT_LSB = 0;
    localparam int ST_EMPTY   = 5;
    localparam int ST_FULL    = 6;
    localparam int ST_OVF     = 7;
    localparam int ST_UND_LSB = 8;

    localparam logic [31:0] SILENCE_W_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        WR1,
        WR2,
        WR3
    } state_t;

    function automatic logic [31:0] stat_word(
        input logic [7:0] und,
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [4:0] cnt
    );
        return {16'h0, und, ovf, full, empty, cnt};
    endfunction

endpackage

// File: rtl/blt_dsp_feeder_if.sv
// CPU register-bus controls plus the DSP write port of the feeder.
// The tristate data line stays a plain port on the feeder itself.
interface blt_dsp_feeder_if;

    logic [31:0] busAddr;
    logic        busOE;
    logic        busWR;
    logic        busHold;
    logic        dspIrqN;
    logic [31:0] dspAddr;
    logic [31:0] dspData;
    logic        dspWR;
    logic        dspHold;
    logic        cpuIrqN;

    modport master (
        output busAddr, busOE, busWR, dspIrqN, dspHold,
        input  busHold, dspAddr, dspData, dspWR, cpuIrqN
    );

    modport slave (
        input  busAddr, busOE, busWR, dspIrqN, dspHold,
        output busHold, dspAddr, dspData, dspWR, cpuIrqN
    );

endinterface

// File: rtl/blt_feed_fifo.sv
// 128-bit synchronous FIFO holding queued sound-block entries.
// Pop reads the pre-push head; a push into a full FIFO succeeds only alongside a pop.
module blt_feed_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [127:0]        din,
    output logic [127:0]        dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [127:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/blt_dsp_feeder.sv
// Buffers CPU-written sound blocks and replays one per DSP tick as four writes.
// Define BLT_FEED_IRQ_EN to enable the low-water refill interrupt on cpuIrqN.
module blt_dsp_feeder
    import blt_feed_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [23:0] CPU_BASE   = 24'hABCDE1,
    parameter logic [31:0] DSP_BASE   = 32'hABCDE000,
    parameter logic [31:0] SILENCE_W  = SILENCE_W_DEF,
    parameter int          LOW_WATER  = 2
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [31:0]       busData,
    blt_dsp_feeder_if.slave   bus
);

    localparam int CW = DEPTH_LOG2 + 1;

    state_t          state;
    state_t          state_n;
    logic            pending;
    logic            pend_n;
    logic            lost;
    logic            enter0;
    logic            tick;
    logic [7:0]      underrun;
    logic            ovf;
    logic [31:0]     stage0;
    logic [31:0]     stage1;
    logic [31:0]     stage2;
    logic [127:0]    latch;
    logic [127:0]    latch_n;
    logic [1:0]      widx;
    logic [31:0]     dsp_addr;
    logic [31:0]     dsp_data;
    logic            dsp_wr;
    logic            irq_n;
    logic            sel;
    logic [5:0]      off;
    logic            wr_en;
    logic            rd_stat;
    logic            push;
    logic            pop;
    logic [127:0]    fifo_dout;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [31:0]     stat;
    logic [1:0]      und_inc;
    logic [8:0]      und_sum;
    logic            unused_ok;

    assign sel     = (bus.busAddr[31:8] == CPU_BASE);
    assign off     = bus.busAddr[7:2];
    assign wr_en   = sel && bus.busWR;
    assign rd_stat = sel && bus.busOE && !bus.busWR && (off == REG_STAT);
    assign push    = wr_en && (off == REG_W3);
    assign pop     = enter0 && !empty;
    assign tick    = !bus.dspIrqN;

    assign stat    = stat_word(underrun, ovf, full, empty, 5'(count));
    assign busData = rd_stat ? stat : 32'hzzzz_zzzz;

    assign bus.busHold = 1'b0;
    assign bus.dspAddr = dsp_addr;
    assign bus.dspData = dsp_data;
    assign bus.dspWR   = dsp_wr;
    assign bus.cpuIrqN = irq_n;

    assign unused_ok = ^{bus.busAddr[1:0], LOW_WATER[0]};

    blt_feed_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({busData, stage2, stage1, stage0}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Next state, pending tick and lost-tick detection for the write sequencer.
    always_comb begin
        state_n = state;
        pend_n  = pending;
        lost    = 1'b0;
        enter0  = 1'b0;
        if (state != IDLE && tick) begin
            if (pending) lost = 1'b1;
            else         pend_n = 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_n = WR0;
                    enter0  = 1'b1;
                end
            end
            WR0: if (!bus.dspHold) state_n = WR1;
            WR1: if (!bus.dspHold) state_n = WR2;
            WR2: if (!bus.dspHold) state_n = WR3;
            WR3: begin
                if (!bus.dspHold) begin
                    pend_n = 1'b0;
                    if (pending || tick) begin
                        state_n = WR0;
                        enter0  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Out-latch contents and the word slot shown in the next cycle.
    always_comb begin
        latch_n = latch;
        widx    = 2'd0;
        if (enter0) latch_n = empty ? {4{SILENCE_W}} : fifo_dout;
        unique case (state_n)
            WR1:     widx = 2'd1;
            WR2:     widx = 2'd2;
            WR3:     widx = 2'd3;
            default: widx = 2'd0;
        endcase
    end

    assign und_inc = 2'(lost) + 2'(enter0 && empty);
    assign und_sum = 9'(underrun) + 9'(und_inc);

    // Sequencer state, pending flag and saturating underrun counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pending  <= 1'b0;
            underrun <= 8'h00;
            latch    <= '0;
        end else begin
            state    <= state_n;
            pending  <= pend_n;
            underrun <= und_sum[8] ? 8'hFF : und_sum[7:0];
            latch    <= latch_n;
        end
    end

    // Registered DSP write port; address/data hold their last value in IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dsp_addr <= '0;
            dsp_data <= '0;
            dsp_wr   <= 1'b0;
        end else begin
            dsp_wr <= (state_n != IDLE);
            if (state_n != IDLE) begin
                dsp_addr <= DSP_BASE + {28'h0, widx, 2'b00};
                dsp_data <= latch_n[32*widx +: 32];
            end
        end
    end

    // Staging words and sticky overflow flag (a status read clears it).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage0 <= '0;
            stage1 <= '0;
            stage2 <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en && off == REG_W0) stage0 <= busData;
            if (wr_en && off == REG_W1) stage1 <= busData;
            if (wr_en && off == REG_W2) stage2 <= busData;
            if (push && full && !pop) ovf <= 1'b1;
            else if (rd_stat)         ovf <= 1'b0;
        end
    end

`ifdef BLT_FEED_IRQ_EN
    localparam logic [CW-1:0] LW = CW'(LOW_WATER);

    // Refill request asserted while the queue is at or below the low-water mark.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) irq_n <= 1'b1;
        else        irq_n <= !(count <= LW);
    end
`else
    assign irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_blt_dsp_feeder.sv
// Randomized bench for blt_dsp_feeder against a queue-based reference model.
// Works with and without BLT_FEED_IRQ_EN defined.
module tb_blt_dsp_feeder;

    localparam logic [23:0] CPU_BASE = 24'hABCDE1;
    localparam logic [31:0] DSP_BASE = 32'hABCDE000;
    localparam int          DEPTH    = 8;
    localparam int          LOW_W    = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    blt_dsp_feeder_if bus();
    wire  [31:0] bus_data;
    logic [31:0] drv;
    logic        drv_en;
    assign bus_data = drv_en ? drv : 32'hzzzz_zzzz;

    blt_dsp_feeder dut (
        .clock   (clock),
        .reset   (reset),
        .busData (bus_data),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit rand_hold = 0;

    logic [127:0] mq[$];
    int           m_und = 0;
    bit           m_ovf = 0;
    logic [31:0]  oa[$];
    logic [31:0]  od[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void m_push(input logic [127:0] e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
    endfunction

    function automatic logic [127:0] m_service();
        if (mq.size() > 0) return mq.pop_front();
        if (m_und < 255) m_und++;
        return 128'h0;
    endfunction

    function automatic logic [31:0] m_stat();
        int n = mq.size();
        return {16'h0, 8'(m_und), m_ovf, n == DEPTH, n == 0, 5'(n)};
    endfunction

    function automatic logic m_irq();
`ifdef BLT_FEED_IRQ_EN
        return (mq.size() <= LOW_W) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    // Accepted DSP writes: strobe high and not stalled.
    always @(negedge clock) begin
        #2;
        if (bus.dspWR && !bus.dspHold) begin
            oa.push_back(bus.dspAddr);
            od.push_back(bus.dspData);
        end
    end

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clock);
        bus.busAddr = addr;
        bus.busWR   = 1;
        drv         = d;
        drv_en      = 1;
        @(negedge clock);
        bus.busWR   = 0;
        drv_en      = 0;
    endtask

    task automatic push_entry(input logic [127:0] e);
        for (int i = 0; i < 4; i++)
            cpu_write({CPU_BASE, 6'(i), 2'b00}, e[32*i +: 32]);
        m_push(e);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] v;
        @(negedge clock);
        bus.busAddr = {CPU_BASE, 6'd4, 2'b00};
        bus.busOE   = 1;
        #1 v = bus_data;
        chk(tag, v, m_stat());
        chk({tag, "_irq"}, 32'(bus.cpuIrqN), 32'(m_irq()));
        m_ovf = 0;
        @(negedge clock);
        bus.busOE = 0;
    endtask

    task automatic pulse();
        @(negedge clock);
        bus.dspIrqN = 0;
        @(negedge clock);
        bus.dspIrqN = 1;
    endtask

    task automatic check_service(input string tag, input logic [127:0] e);
        int t = 0;
        while (oa.size() < 4 && t < 60) begin
            @(negedge clock);
            if (rand_hold) bus.dspHold = ($urandom_range(0, 2) == 0);
            t++;
        end
        bus.dspHold = 0;
        chk({tag, "_done"}, 32'(oa.size() >= 4), 32'd1);
        if (oa.size() >= 4) begin
            for (int n = 0; n < 4; n++) begin
                chk({tag, "_addr"}, oa.pop_front(), DSP_BASE + 32'(4 * n));
                chk({tag, "_data"}, od.pop_front(), e[32*n +: 32]);
            end
        end
    endtask

    function automatic logic [127:0] rnd_entry();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [127:0] ea;
        logic [127:0] eb;
        bus.busAddr = 0;
        bus.busOE   = 0;
        bus.busWR   = 0;
        bus.dspIrqN = 1;
        bus.dspHold = 0;
        drv         = 0;
        drv_en      = 0;

        #12;
        chk("rst_wr", 32'(bus.dspWR), 32'd0);
        chk("rst_addr", bus.dspAddr, 32'd0);
        chk("rst_data", bus.dspData, 32'd0);
        chk("rst_hold", 32'(bus.busHold), 32'd0);
        chk("rst_irq", 32'(bus.cpuIrqN), 32'd1);
        @(negedge clock);
        reset = 1;
        check_status("rst_stat");

        // T1: one entry replayed on four consecutive cycles
        push_entry({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        check_status("t1_stat1");
        pulse();
        for (int n = 0; n < 4; n++) begin
            chk("t1_wr", 32'(bus.dspWR), 32'd1);
            chk("t1_addr", bus.dspAddr, DSP_BASE + 32'(4 * n));
            chk("t1_data", bus.dspData, 32'h11111111 * (n + 1));
            @(negedge clock);
        end
        chk("t1_idle", 32'(bus.dspWR), 32'd0);
        oa.delete();
        od.delete();
        void'(m_service());
        check_status("t1_stat0");

        // T2: underrun writes silence
        pulse();
        check_service("t2", m_service());
        check_status("t2_stat");

        // T3: overfill then drain
        for (int i = 0; i < 9; i++) push_entry(rnd_entry());
        check_status("t3_full");
        check_status("t3_ovfclr");
        for (int i = 0; i < 8; i++) begin
            pulse();
            check_service("t3_drain", m_service());
        end

        // T4: stall during WR1
        push_entry(rnd_entry());
        pulse();
        @(negedge clock);
        chk("t4_wr1", bus.dspAddr, DSP_BASE + 32'd4);
        bus.dspHold = 1;
        repeat (3) begin
            @(negedge clock);
            chk("t4_held", bus.dspAddr, DSP_BASE + 32'd4);
            chk("t4_heldwr", 32'(bus.dspWR), 32'd1);
        end
        bus.dspHold = 0;
        @(negedge clock);
        chk("t4_wr2", bus.dspAddr, DSP_BASE + 32'd8);
        check_service("t4", m_service());

        // T5: ticks during WR2 and WR3
        push_entry(rnd_entry());
        push_entry(rnd_entry());
        pulse();
        @(negedge clock);
        @(negedge clock);
        bus.dspIrqN = 0;
        @(negedge clock);
        @(negedge clock);
        bus.dspIrqN = 1;
        chk("t5_b2b_wr", 32'(bus.dspWR), 32'd1);
        chk("t5_b2b_addr", bus.dspAddr, DSP_BASE);
        ea = m_service();
        eb = m_service();
        if (m_und < 255) m_und++;
        check_service("t5_a", ea);
        check_service("t5_b", eb);
        check_status("t5_stat");

        // T6: refill request follows count with one cycle of lag
        for (int i = 0; i < 3; i++) push_entry(rnd_entry());
        check_status("t6_cnt3");
        pulse();
        chk("t6_lag", 32'(bus.cpuIrqN), 32'd1);
        @(negedge clock);
`ifdef BLT_FEED_IRQ_EN
        chk("t6_low", 32'(bus.cpuIrqN), 32'd0);
`else
        chk("t6_low", 32'(bus.cpuIrqN), 32'd1);
`endif
        check_service("t6", m_service());
        check_status("t6_cnt2");
        push_entry(rnd_entry());
        check_status("t6_cnt3b");

        // Randomized traffic
        repeat (150) begin
            int r = $urandom_range(0, 9);
            if (r <= 3) begin
                push_entry(rnd_entry());
            end else if (r == 4) begin
                if ($urandom_range(0, 1) == 1)
                    cpu_write({CPU_BASE, 6'($urandom_range(5, 63)), 2'b00}, $urandom);
                else
                    cpu_write({CPU_BASE ^ 24'h000010, 6'd3, 2'b00}, $urandom);
            end else if (r <= 6) begin
                check_status("rnd_stat");
            end else begin
                rand_hold = ($urandom_range(0, 1) == 1);
                pulse();
                check_service("rnd", m_service());
                rand_hold = 0;
            end
        end
        check_status("rnd_final");

        // Reset in the middle of a sequence
        push_entry(rnd_entry());
        pulse();
        @(negedge clock);
        reset = 0;
        #1;
        chk("mid_rst_wr", 32'(bus.dspWR), 32'd0);
        @(negedge clock);
        reset = 1;
        mq.delete();
        m_und = 0;
        m_ovf = 0;
        repeat (3) @(negedge clock);
        chk("mid_rst_idle", 32'(bus.dspWR), 32'd0);
        oa.delete();
        od.delete();
        check_status("mid_rst_stat");
        pulse();
        check_service("mid_rst_svc", m_service());

        repeat (8) @(negedge clock);
        chk("no_extra", 32'(oa.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
